// File: rtl/ksz_bus_ctrl.sv
// ksz_bus_ctrl: host-bus access engine for the KSZ8851 16-bit Ethernet
// controller. Each command from the initiator becomes one command (address)
// cycle followed by one data read or data write cycle on CSn/RDn/WRn/CMD/SD.
//
// Optional build macro: BUS_ACCESS_COUNT_EN adds rdCount/wrCount access
// counters. Without it those ports and their logic are absent.
//
// Handshake: the initiator holds NewCommand=1 with offset/length/WR valid.
// NewCommand is sampled only in Wait, Read2 and Write2. offset/length/WR
// are captured on the edge that enters Addr0. writeData is captured on the
// edge that enters Write0. readData is updated at the end of Read1 and holds
// until the next Read1 completes.
//
// Ports:
//   clk40m      in   40 MHz clock
//   reset       in   asynchronous, active-low reset
//   offset      in   [7:0] register byte address
//   length      in   1 = 16-bit word access, 0 = byte access
//   WR          in   1 = write, 0 = read
//   writeData   in   [15:0] write data
//   NewCommand  in   command request level
//   readData    out  [15:0] last read result
//   state       out  [3:0] current FSM state (published for pipelining)
//   eth_csn     out  chip select, active low
//   eth_rdn     out  read strobe, active low
//   eth_wrn     out  write strobe, active low
//   eth_cmd     out  1 = command cycle, 0 = data cycle
//   sd_out      out  [15:0] bus drive value
//   sd_oe       out  bus output enable
//   sd_in       in   [15:0] bus sample value
//   rdCount     out  [15:0] completed reads (BUS_ACCESS_COUNT_EN only)
//   wrCount     out  [15:0] completed writes (BUS_ACCESS_COUNT_EN only)
module ksz_bus_ctrl #(
    parameter int ADDR_STROBE   = 1,  // cycles WRn held low in Addr1 (>= 1)
    parameter int STROBE_CYCLES = 1   // cycles spent in Read0/Write0 (>= 1)
) (
    input  logic        clk40m,
    input  logic        reset,
    input  logic [7:0]  offset,
    input  logic        length,
    input  logic        WR,
    input  logic [15:0] writeData,
    input  logic        NewCommand,
    output logic [15:0] readData,
    output logic [3:0]  state,
    output logic        eth_csn,
    output logic        eth_rdn,
    output logic        eth_wrn,
    output logic        eth_cmd,
    output logic [15:0] sd_out,
    output logic        sd_oe,
    input  logic [15:0] sd_in
`ifdef BUS_ACCESS_COUNT_EN
    ,
    output logic [15:0] rdCount,
    output logic [15:0] wrCount
`endif
);

    localparam logic [3:0] S_ADDR0  = 4'd0;
    localparam logic [3:0] S_ADDR1  = 4'd1;
    localparam logic [3:0] S_ADDR2  = 4'd2;
    localparam logic [3:0] S_READ0  = 4'd3;
    localparam logic [3:0] S_READ1  = 4'd4;
    localparam logic [3:0] S_READ2  = 4'd5;
    localparam logic [3:0] S_WRITE0 = 4'd6;
    localparam logic [3:0] S_WRITE1 = 4'd7;
    localparam logic [3:0] S_WRITE2 = 4'd8;
    localparam logic [3:0] S_WAIT   = 4'd9;

    // 8-bit dwell counter: both strobe parameters must stay below 257.
    localparam logic [7:0] ADDR_LAST   = 8'(ADDR_STROBE - 1);
    localparam logic [7:0] STROBE_LAST = 8'(STROBE_CYCLES - 1);

    logic [3:0]  cur_state;
    logic [3:0]  next_state;
    logic [7:0]  cnt;
    logic        wr_lat;
    logic [15:0] sd_reg;
    logic [3:0]  be;
    logic [15:0] cmd_word;

    assign state  = cur_state;
    assign sd_out = sd_reg;

    // Byte enables: a word uses one half selected by offset[1], a byte uses
    // one lane selected by offset[1:0].
    always_comb begin
        be = 4'b0000;
        if (length) begin
            be = offset[1] ? 4'b1100 : 4'b0011;
        end else begin
            be = 4'b0001 << offset[1:0];
        end
    end

    assign cmd_word = {be, 4'b0000, offset[7:2], 2'b00};

    // State register. Async reset returns to Wait, which drives every strobe
    // inactive combinationally, so an interrupted access ends on that edge.
    always_ff @(posedge clk40m or negedge reset) begin
        if (!reset) begin
            cur_state <= S_WAIT;
        end else begin
            cur_state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = cur_state;
        case (cur_state)
            S_WAIT:   if (NewCommand) next_state = S_ADDR0;
            S_ADDR0:  next_state = S_ADDR1;
            S_ADDR1:  if (cnt == ADDR_LAST) next_state = S_ADDR2;
            S_ADDR2:  next_state = wr_lat ? S_WRITE0 : S_READ0;
            S_READ0:  if (cnt == STROBE_LAST) next_state = S_READ1;
            S_READ1:  next_state = S_READ2;
            S_READ2:  next_state = NewCommand ? S_ADDR0 : S_WAIT;
            S_WRITE0: if (cnt == STROBE_LAST) next_state = S_WRITE1;
            S_WRITE1: next_state = S_WRITE2;
            S_WRITE2: next_state = NewCommand ? S_ADDR0 : S_WAIT;
            default:  next_state = S_WAIT;
        endcase
    end

    // Output decode, purely from state so strobes follow reset instantly.
    always_comb begin
        eth_csn = 1'b1;
        eth_rdn = 1'b1;
        eth_wrn = 1'b1;
        eth_cmd = 1'b0;
        sd_oe   = 1'b0;
        case (cur_state)
            S_ADDR0:  begin eth_csn = 1'b0; eth_cmd = 1'b1; sd_oe = 1'b1; end
            S_ADDR1:  begin eth_csn = 1'b0; eth_cmd = 1'b1; sd_oe = 1'b1; eth_wrn = 1'b0; end
            S_ADDR2:  begin eth_csn = 1'b0; sd_oe = 1'b1; end
            S_READ0:  begin eth_csn = 1'b0; eth_rdn = 1'b0; end
            S_READ1:  begin eth_csn = 1'b0; eth_rdn = 1'b0; end
            S_WRITE0: begin eth_csn = 1'b0; eth_wrn = 1'b0; sd_oe = 1'b1; end
            S_WRITE1: begin eth_csn = 1'b0; eth_wrn = 1'b0; sd_oe = 1'b1; end
            // Bus kept driven one cycle past the strobe for data hold time.
            S_WRITE2: begin sd_oe = 1'b1; end
            default:  ;
        endcase
    end

    // Datapath: dwell counter, command latch, bus data and read capture.
    always_ff @(posedge clk40m or negedge reset) begin
        if (!reset) begin
            cnt      <= 8'd0;
            wr_lat   <= 1'b0;
            sd_reg   <= 16'h0000;
            readData <= 16'h0000;
`ifdef BUS_ACCESS_COUNT_EN
            rdCount  <= 16'h0000;
            wrCount  <= 16'h0000;
`endif
        end else begin
            cnt <= (next_state != cur_state) ? 8'd0 : cnt + 8'd1;
            if (next_state == S_ADDR0) begin
                wr_lat <= WR;
                sd_reg <= cmd_word;
            end
            if (cur_state == S_ADDR2 && next_state == S_WRITE0) begin
                sd_reg <= writeData;
            end
            if (cur_state == S_READ1) begin
                readData <= sd_in;
            end
`ifdef BUS_ACCESS_COUNT_EN
            if (cur_state == S_READ1)  rdCount <= rdCount + 16'd1;
            if (cur_state == S_WRITE1) wrCount <= wrCount + 16'd1;
`endif
        end
    end

endmodule
